decay_rate_estimator: RTL and testbench
=======================================

// Module: decay_rate_estimator
// PURPOSE
//  Parametrised successor to the fixed 8-bit sample counter/estimator. Collects a runtime-selected
//  number of samples over a valid/ready stream and tracks a recursive half-average N, a running sum C
//  of N, and the first sample C0. It then computes est = (C - (C0+N)/2) / (C0 - N) with a multi-cycle divider.
//  Sits between the sample front end and the result register bank. Adds start/done handshake, divide-by-zero flag.
// PARAMETERS
//  DATA_W  8   sample width (C0, N widths)
//  CNT_W   8   width of m_len / sample counter
//  ACC_W   32  width of C, numerator, denominator, divider
//  OUT_W   32  result width (OUT_W <= ACC_W; quotient truncated to OUT_W LSBs)
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       asynchronous reset, active-low
//  start     in   1       begin run; sampled only in IDLE
//  m_len     in   CNT_W   samples per run; latched when start accepted
//  in_valid  in   1       sample valid
//  in_data   in   DATA_W  sample, unsigned
//  in_ready  out  1       high only in ACCUM
//  busy      out  1       high in every state except IDLE
//  out_valid out  1       one-cycle pulse in DONE
//  out_data  out  OUT_W   result; held from DONE until next accepted start
//  div_zero  out  1       valid with out_valid; held like out_data
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; C, C0, N, k, quotient/remainder regs=0.
//   All outputs 0: in_ready, busy, out_valid, out_data, div_zero.
//  FSM: IDLE -> ACCUM -> PREP -> DIV -> DONE -> IDLE.
//  IDLE: start=1 latches m_len and clears C, C0, N, k, out_data, div_zero.
//   If m_len!=0, go to ACCUM. If m_len==0, go straight to DONE with out_data=0, div_zero=1.
//   start outside IDLE is ignored; no queuing.
//  ACCUM: accept a sample on in_valid && in_ready.
//   On k==0: C0 <= x.
//   Every accepted sample: h = (N + x) >> 1, computed at DATA_W+1 bits, no overflow. Then N <= h, C <= C + h (ACC_W, wraps mod 2^ACC_W); k <= k+1.
//   When the m_len-th sample is accepted, go to PREP on the next edge. in_valid gaps stall without loss.
//  PREP (1 cycle):
//   half = (C0 + N) >> 1, computed at DATA_W+1 bits.
//   num = C - half if C >= half, else 0 (saturating).
//   If C0 <= N: div_zero <= 1, out_data <= all ones, go to DONE.
//   Otherwise den = C0 - N, go to DIV.
//  DIV: unsigned restoring divide, exactly one quotient bit per cycle, MSB first, ACC_W cycles.
//   Then out_data <= quotient[OUT_W-1:0]; go to DONE.
//  DONE (1 cycle): out_valid=1, then IDLE.
//  Latency: the last sample accepted at edge T gives out_valid high during cycle T+ACC_W+2, i.e. 34 for defaults.
//   div_zero path: out_valid high during cycle T+2.
//  Reset mid-run: abort immediately, no out_valid, all regs and outputs return to reset values.
//  All arithmetic is unsigned. Remainder is discarded (truncating divide).
// TESTING
//  1. m_len=4, samples 100,50,25,12
//     -> N=24, C=161, C0=100, num=99, den=76; out_data=1, div_zero=0, out_valid at T+34.
//  2. m_len=4, samples 10,10,10,10
//     -> N=9, C=29, num=20, den=1; out_data=20.
//  3. m_len=2, samples 0,50
//     -> C0=0 <= N=25; div_zero=1, out_data=32'hFFFF_FFFF, out_valid at T+2.
//  4. m_len=1, sample 100
//     -> C=50, half=75, num saturates to 0, den=50; out_data=0, div_zero=0.
//  5. Test 1 with in_valid deasserted 3 cycles between samples, plus start pulsed during DIV
//     -> same result, start ignored, exactly one out_valid.
//  6. rst low in DIV cycle 10, then start with m_len=0
//     -> no out_valid from aborted run; next run out_valid with out_data=0, div_zero=1.

Source files
------------

// File: rtl/decay_rate_estimator_if.sv
// Sample stream between the front end and the decay-rate estimator.
// The producer drives valid/data; the estimator drives ready.
interface decay_rate_estimator_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/decay_rate_estimator.sv
// Collects m_len samples, tracks half-average N, running sum C and first sample C0,
// then computes (C - (C0+N)/2) / (C0 - N) with a bit-serial restoring divider.
module decay_rate_estimator #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     m_len,
    decay_rate_estimator_if.slave s,
    output logic                 busy,
    output logic                 out_valid,
    output logic [OUT_W-1:0]     out_data,
    output logic                 div_zero
);
    localparam int DCNT_W = $clog2(ACC_W);

    typedef enum logic [2:0] {IDLE, ACCUM, PREP, DIV, DONE} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    len_q, k;
    logic [DATA_W-1:0]   c0, n;
    logic [ACC_W-1:0]    c, den, quo, rem;
    logic [DCNT_W-1:0]   dcnt;

    logic                accept, last_sample, c0_le_n, fits, div_last;
    logic [DATA_W:0]     sum_nx, h, sum_c0n, half;
    logic [ACC_W-1:0]    half_ext, num, rem_nx, quo_nx;
    logic [ACC_W:0]      shifted;

    assign accept      = (state == ACCUM) && s.in_valid;
    assign last_sample = (k == len_q - 1'b1);
    assign sum_nx      = {1'b0, n} + {1'b0, s.in_data};
    assign h           = sum_nx >> 1;
    assign sum_c0n     = {1'b0, c0} + {1'b0, n};
    assign half        = sum_c0n >> 1;
    assign half_ext    = ACC_W'(half);
    assign num         = (c >= half_ext) ? (c - half_ext) : '0;
    assign c0_le_n     = (c0 <= n);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign shifted  = {rem, quo[ACC_W-1]};
    assign fits     = (shifted >= {1'b0, den});
    assign rem_nx   = fits ? ACC_W'(shifted - {1'b0, den}) : shifted[ACC_W-1:0];
    assign quo_nx   = {quo[ACC_W-2:0], fits};
    assign div_last = (dcnt == DCNT_W'(ACC_W - 1));

    assign s.in_ready = (state == ACCUM);
    assign busy       = (state != IDLE);
    assign out_valid  = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (m_len == '0) ? DONE : ACCUM;
            ACCUM:   if (accept && last_sample) state_nx = PREP;
            PREP:    state_nx = c0_le_n ? DONE : DIV;
            DIV:     if (div_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q    <= '0;
            k        <= '0;
            c0       <= '0;
            n        <= '0;
            c        <= '0;
            den      <= '0;
            quo      <= '0;
            rem      <= '0;
            dcnt     <= '0;
            out_data <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A zero-length run reports divide-by-zero with a zero result.
                    if (start) begin
                        len_q    <= m_len;
                        k        <= '0;
                        c0       <= '0;
                        n        <= '0;
                        c        <= '0;
                        out_data <= '0;
                        div_zero <= (m_len == '0);
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (k == '0) c0 <= s.in_data;
                        n <= h[DATA_W-1:0];
                        c <= c + ACC_W'(h);
                        k <= k + 1'b1;
                    end
                end
                PREP: begin
                    if (c0_le_n) begin
                        div_zero <= 1'b1;
                        out_data <= '1;
                    end else begin
                        den  <= ACC_W'(c0 - n);
                        quo  <= num;
                        rem  <= '0;
                        dcnt <= '0;
                    end
                end
                DIV: begin
                    quo  <= quo_nx;
                    rem  <= rem_nx;
                    dcnt <= dcnt + 1'b1;
                    if (div_last) out_data <= quo_nx[OUT_W-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_decay_rate_estimator.sv
// Directed bench for decay_rate_estimator: hand-computed results, latency,
// handshake behaviour, start-ignore and mid-run reset.
module tb_decay_rate_estimator;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  m_len;
    logic        busy, out_valid, div_zero;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;
    int lat, pulses;
    bit seen;

    decay_rate_estimator_if #(.DATA_W(8)) s_if ();

    decay_rate_estimator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .m_len     (m_len),
        .s         (s_if),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one estimate; lat counts clock edges after the last accepted sample
    // until out_valid is seen, pulses counts out_valid cycles in the window.
    task automatic applyStimulus(input logic [7:0] len, input logic [31:0] smp,
                                 input int gap, input int pulse_at, input int reset_at,
                                 output int lat_o, output bit seen_o, output int pulses_o);
        @(negedge clk);
        start = 1'b1;
        m_len = len;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("in_ready_accum", {31'b0, s_if.in_ready}, 32'd1);
        for (int i = 0; i < int'(len) && i < 4; i++) begin
            for (int g = 0; g < gap && i > 0; g++) begin
                @(posedge clk);
                @(negedge clk);
            end
            s_if.in_valid = 1'b1;
            s_if.in_data  = smp[31-8*i -: 8];
            @(posedge clk);
            @(negedge clk);
            s_if.in_valid = 1'b0;
        end
        lat_o    = 0;
        seen_o   = 1'b0;
        pulses_o = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (out_valid) begin
                if (!seen_o) lat_o = cyc;
                seen_o = 1'b1;
                pulses_o++;
            end
            if (cyc == reset_at) begin
                rst = 1'b0;
                break;
            end
            start = (cyc == pulse_at);
            if (cyc == pulse_at) m_len = 8'd3;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        start         = 1'b0;
        m_len         = 8'd0;
        s_if.in_valid = 1'b0;
        s_if.in_data  = 8'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, s_if.in_ready}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_div_zero", {31'b0, div_zero}, 32'd0);
        rst = 1'b1;

        $display("[TB] test 1: 100,50,25,12");
        applyStimulus(8'd4, {8'd100, 8'd50, 8'd25, 8'd12}, 0, -1, -1, lat, seen, pulses);
        checkOutput("t1_seen", {31'b0, seen}, 32'd1);
        checkOutput("t1_latency", lat + 1, 32'd34);
        checkOutput("t1_pulses", pulses, 32'd1);
        checkOutput("t1_out_data", out_data, 32'd1);
        checkOutput("t1_div_zero", {31'b0, div_zero}, 32'd0);
        checkOutput("t1_busy", {31'b0, busy}, 32'd0);

        $display("[TB] test 2: 10,10,10,10");
        applyStimulus(8'd4, {8'd10, 8'd10, 8'd10, 8'd10}, 0, -1, -1, lat, seen, pulses);
        checkOutput("t2_latency", lat + 1, 32'd34);
        checkOutput("t2_out_data", out_data, 32'd20);
        checkOutput("t2_div_zero", {31'b0, div_zero}, 32'd0);

        $display("[TB] test 3: 0,50 divide by zero");
        applyStimulus(8'd2, {8'd0, 8'd50, 8'd0, 8'd0}, 0, -1, -1, lat, seen, pulses);
        checkOutput("t3_latency", lat + 1, 32'd2);
        checkOutput("t3_pulses", pulses, 32'd1);
        checkOutput("t3_out_data", out_data, 32'hFFFF_FFFF);
        checkOutput("t3_div_zero", {31'b0, div_zero}, 32'd1);

        $display("[TB] test 4: single sample 100");
        applyStimulus(8'd1, {8'd100, 8'd0, 8'd0, 8'd0}, 0, -1, -1, lat, seen, pulses);
        checkOutput("t4_latency", lat + 1, 32'd34);
        checkOutput("t4_out_data", out_data, 32'd0);
        checkOutput("t4_div_zero", {31'b0, div_zero}, 32'd0);

        $display("[TB] test 5: gaps and start during divide");
        applyStimulus(8'd4, {8'd100, 8'd50, 8'd25, 8'd12}, 3, 15, -1, lat, seen, pulses);
        checkOutput("t5_latency", lat + 1, 32'd34);
        checkOutput("t5_pulses", pulses, 32'd1);
        checkOutput("t5_out_data", out_data, 32'd1);
        checkOutput("t5_busy", {31'b0, busy}, 32'd0);

        $display("[TB] test 6: reset during divide, then zero-length run");
        applyStimulus(8'd4, {8'd100, 8'd50, 8'd25, 8'd12}, 0, -1, 10, lat, seen, pulses);
        #1;
        checkOutput("t6_no_result", {31'b0, seen}, 32'd0);
        checkOutput("t6_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("t6_rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("t6_rst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checkOutput("t6_post_rst_pulses", pulses, 32'd0);
        start = 1'b1;
        m_len = 8'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("t6_out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("t6_out_data", out_data, 32'd0);
        checkOutput("t6_div_zero", {31'b0, div_zero}, 32'd1);
        @(negedge clk);
        checkOutput("t6_pulse_end", {31'b0, out_valid}, 32'd0);
        checkOutput("t6_idle", {31'b0, busy}, 32'd0);
        checkOutput("t6_hold_div_zero", {31'b0, div_zero}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
